// File: rtl/bw_mult_pkg.sv
// bw_mult_pkg: shared types and widths for the multiplier scheduler
package bw_mult_pkg;
  localparam int OP_W = 4;
  localparam int P_W = 8;
  localparam int MAX_REQ = 4;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_e;
endpackage

// File: rtl/BW_Multiplier.sv
// BW_Multiplier: combinational 4x4 signed Baugh-Wooley multiplier
module BW_Multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  // Sign-row partial products are inverted; the 0x90 constant restores the signed result
  always_comb begin
    p = 8'h90;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        p = p + (8'((a[i] & b[j]) ^ ((i == 3) ^ (j == 3))) << (i + j));
  end
endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker starting the search at rr_ptr
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);
  logic [NREQ-1:0] rot;
  int off;
  int s;
  // Rotate so rr_ptr sits at bit 0, find the first valid, then map back modulo NREQ
  always_comb begin
    rot = NREQ'({req_valid, req_valid} >> rr_ptr);
    off = 0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) off = k;
    s = int'(rr_ptr) + off;
    s = (s >= NREQ) ? s - NREQ : s;
    gnt_id = IDW'(s);
    gnt = (|rot) ? NREQ'(1) << s : '0;
  end
endmodule

// File: rtl/bw_mult_sched.sv
// bw_mult_sched: round-robin sharing of one 4x4 signed multiplier among NREQ requesters
module bw_mult_sched
  import bw_mult_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [P_W-1:0]    rsp_p,
  output logic              busy
);
  state_e state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, cur_id_q, cur_id_d, rsp_id_q, rsp_id_d, gnt_id;
  logic [OP_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [P_W-1:0] rsp_p_q, rsp_p_d, prod;
  logic rsp_valid_q, rsp_valid_d;
  logic [NREQ-1:0] gnt;
  logic acc, hs;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid(req_valid),
    .rr_ptr(rr_ptr_q),
    .gnt(gnt),
    .gnt_id(gnt_id)
  );

  BW_Multiplier u_mult (
    .a(op_a_q),
    .b(op_b_q),
    .p(prod)
  );

  // Grant only in IDLE; rsp_valid is registered so it rises one cycle into RESP
  always_comb begin
    req_ready = (state_q == S_IDLE && !rst) ? gnt : '0;
    acc = |(req_valid & req_ready);
    hs = rsp_valid_q & rsp_ready;
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    cur_id_d = cur_id_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    rsp_p_d = rsp_p_q;
    rsp_id_d = rsp_id_q;
    rsp_valid_d = (state_q == S_RESP) && !hs;
    case (state_q)
      S_IDLE:
        if (acc) begin
          state_d = S_CALC;
          cur_id_d = gnt_id;
          rr_ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
          for (int i = 0; i < NREQ; i++)
            if (gnt[i]) begin
              op_a_d = req_a[i*OP_W +: OP_W];
              op_b_d = req_b[i*OP_W +: OP_W];
            end
        end
      S_CALC: begin
        state_d = S_RESP;
        rsp_p_d = prod;
        rsp_id_d = cur_id_q;
      end
      S_RESP: state_d = hs ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_ptr_q <= '0;
      cur_id_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      rsp_p_q <= '0;
      rsp_id_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cur_id_q <= cur_id_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      rsp_p_q <= rsp_p_d;
      rsp_id_q <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_p = rsp_p_q;
  assign rsp_id = rsp_id_q;
  assign busy = state_q != S_IDLE;
endmodule
